// File: rtl/cross_product_pkg.sv
// ============================================================================
//  Module : cross_product_pkg
//  Brief  : Shared types and defaults for the sequenced fixed-point cross product.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cross_product_pkg;

    localparam int N_DEFAULT    = 32;
    localparam int FRAC_DEFAULT = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [2:0] step_t;

    localparam step_t STEP_LAST = 3'd5;

endpackage

`default_nettype wire

// File: rtl/fxp_mul_signed.sv
// ============================================================================
//  Module : fxp_mul_signed
//  Brief  : Combinational signed NxN -> 2N multiplier shared by all product steps.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fxp_mul_signed #(
    parameter int N = 32
) (
    input  logic signed [N-1:0]   a_i,
    input  logic signed [N-1:0]   b_i,
    output logic signed [2*N-1:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

`default_nettype wire

// File: rtl/cross_product_seq.sv
// ============================================================================
//  Module : cross_product_seq
//  Brief  : Sequenced 3-D signed fixed-point cross product c = a x b using one
//           shared multiplier over six steps. Define CROSS_PRODUCT_SEQ_SAT_EN
//           to saturate components instead of wrapping.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cross_product_seq
    import cross_product_pkg::*;
#(
    parameter int N          = N_DEFAULT,
    parameter int FRAC_WIDTH = FRAC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] x0,
    input  logic signed [N-1:0] y0,
    input  logic signed [N-1:0] z0,
    input  logic signed [N-1:0] x1,
    input  logic signed [N-1:0] y1,
    input  logic signed [N-1:0] z1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] x2,
    output logic signed [N-1:0] y2,
    output logic signed [N-1:0] z2,
    output logic                busy
);

    state_e                 state_q, state_d;
    step_t                  step_q;
    logic signed [N-1:0]    ax_q, ay_q, az_q, bx_q, by_q, bz_q;
    logic signed [2*N-1:0]  acc_q;
    logic signed [N-1:0]    x2_q, y2_q, z2_q;
    logic                   out_valid_q;

    logic signed [N-1:0]    w_mul_a, w_mul_b;
    logic signed [2*N-1:0]  w_prod;
    logic signed [2*N:0]    w_diff;
    logic signed [2*N:0]    w_shift;
    logic signed [N-1:0]    w_res;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)            state_d = MUL;
            MUL:     if (step_q == STEP_LAST) state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign x2        = x2_q;
    assign y2        = y2_q;
    assign z2        = z2_q;

    // ------------------------------------------------------------------
    // Operand selection: even steps form the minuend, odd the subtrahend
    // ------------------------------------------------------------------
    always_comb begin
        w_mul_a = ay_q;
        w_mul_b = bz_q;
        case (step_q)
            3'd0:    begin w_mul_a = ay_q; w_mul_b = bz_q; end
            3'd1:    begin w_mul_a = az_q; w_mul_b = by_q; end
            3'd2:    begin w_mul_a = az_q; w_mul_b = bx_q; end
            3'd3:    begin w_mul_a = ax_q; w_mul_b = bz_q; end
            3'd4:    begin w_mul_a = ax_q; w_mul_b = by_q; end
            3'd5:    begin w_mul_a = ay_q; w_mul_b = bx_q; end
            default: begin w_mul_a = ay_q; w_mul_b = bz_q; end
        endcase
    end

    fxp_mul_signed #(
        .N (N)
    ) u_mul (
        .a_i (w_mul_a),
        .b_i (w_mul_b),
        .p_o (w_prod)
    );

    // One extra bit keeps the difference of two full-range products exact
    assign w_diff  = {acc_q[2*N-1], acc_q} - {w_prod[2*N-1], w_prod};
    assign w_shift = w_diff >>> FRAC_WIDTH;

`ifdef CROSS_PRODUCT_SEQ_SAT_EN
    localparam logic signed [N-1:0] c_sat_max = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] c_sat_min = {1'b1, {(N-1){1'b0}}};

    always_comb begin
        w_res = w_shift[N-1:0];
        if (!((&w_shift[2*N:N-1]) || !(|w_shift[2*N:N-1]))) begin
            w_res = w_shift[2*N] ? c_sat_min : c_sat_max;
        end
    end
`else
    logic w_unused_hi;

    assign w_unused_hi = ^w_shift[2*N:N];

    always_comb begin
        w_res = w_shift[N-1:0];
    end
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= '0;
            ax_q        <= '0;
            ay_q        <= '0;
            az_q        <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            bz_q        <= '0;
            acc_q       <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            z2_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ax_q   <= x0;
                        ay_q   <= y0;
                        az_q   <= z0;
                        bx_q   <= x1;
                        by_q   <= y1;
                        bz_q   <= z1;
                        step_q <= '0;
                    end
                end
                MUL: begin
                    step_q <= step_q + 3'd1;
                    if (!step_q[0]) begin
                        acc_q <= w_prod;
                    end else begin
                        case (step_q[2:1])
                            2'd0:    x2_q <= w_res;
                            2'd1:    y2_q <= w_res;
                            default: z2_q <= w_res;
                        endcase
                    end
                    if (step_q == STEP_LAST) begin
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: out_valid_q <= 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire
